// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared types and constants for the keypad entry path
//   key indices  : KEY_1..KEY_9 are keypad bits 0..8, KEY_0 is keypad bit 9
//   bcd_t        : one stored BCD digit
//   deb_state_t  : debouncer state encoding
//   key_class_t  : per-cycle classification of the sampled keypad
package microwave_pkg;

    localparam int NUM_KEYS                = 10;
    localparam int KEY_1                   = 0;
    localparam int KEY_9                   = 8;
    localparam int KEY_0                   = 9;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        RELEASED     = 2'd1,
        PRESSING     = 2'd2,
        HELD         = 2'd3
    } deb_state_t;

    typedef enum logic [1:0] {
        KC_IDLE    = 2'd0,
        KC_ONEHOT  = 2'd1,
        KC_INVALID = 2'd2
    } key_class_t;

    // Digit keys 1..9 sit on bits 0..8; bit 9 (and an empty pattern) is 0.
    function automatic bcd_t onehot_to_bcd(input logic [NUM_KEYS-1:0] k);
        bcd_t r;
        r = 4'd0;
        for (int i = KEY_1; i <= KEY_9; i++) begin
            if (k[i]) begin
                r = bcd_t'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - keypad classifier and debouncer producing one accept per press
//   clk, clear : clock, asynchronous active-high reset
//   keypad     : raw one-bit-per-key pattern
//   accept     : combinational pulse during the cycle whose edge accepts the key
//   code       : BCD value of the key being debounced
module key_debounce
    import microwave_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [NUM_KEYS-1:0] keypad,
    output logic                accept,
    output logic [3:0]          code
);

    localparam int                CNT_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    deb_state_t          state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [NUM_KEYS-1:0] key_q, key_n;
    key_class_t          kclass;
    logic                match;

    always_comb begin
        kclass = KC_INVALID;
        if (keypad == '0) begin
            kclass = KC_IDLE;
        end else if ((keypad & (keypad - 1'b1)) == '0) begin
            kclass = KC_ONEHOT;
        end
    end

    // An INVALID pattern can never equal the captured one-hot code.
    assign match = (keypad == key_q);
    assign code  = onehot_to_bcd(key_q);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= WAIT_RELEASE;
            cnt   <= '0;
            key_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            key_q <= key_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        key_n   = key_q;
        accept  = 1'b0;
        case (state)
            WAIT_RELEASE: begin
                if (kclass != KC_IDLE) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = RELEASED;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RELEASED: begin
                if (kclass == KC_ONEHOT) begin
                    key_n = keypad;
                    if (DEBOUNCE_CYCLES < 2) begin
                        accept  = 1'b1;
                        state_n = HELD;
                    end else begin
                        state_n = PRESSING;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            PRESSING: begin
                if (!match) begin
                    state_n = RELEASED;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    accept  = 1'b1;
                    state_n = HELD;
                    cnt_n   = cnt + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!match) begin
                    state_n = WAIT_RELEASE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = WAIT_RELEASE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - microwave time entry: debounced keypad into a 3-digit BCD shift window
//   clk, clear                  : clock, asynchronous active-high reset
//   keypad                      : one bit per key (bits 0..8 = 1..9, bit 9 = 0)
//   load_en                     : digit entry permitted
//   sec_ones, sec_tens, mins    : stored BCD digits, unvalidated
//   key_strobe                  : one-cycle pulse after each loaded digit
//   entry_valid                 : any stored digit nonzero
module keypad_entry
    import microwave_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                load_en,
    output logic [3:0]          sec_ones,
    output logic [3:0]          sec_tens,
    output logic [3:0]          mins,
    output logic                key_strobe,
    output logic                entry_valid
);

    logic accept;
    bcd_t code;
    logic load;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk    (clk),
        .clear  (clear),
        .keypad (keypad),
        .accept (accept),
        .code   (code)
    );

    // An accept while entry is locked out is simply dropped; the debouncer
    // has already moved to HELD, so the press cannot be replayed.
    assign load = accept && load_en;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sec_ones   <= '0;
            sec_tens   <= '0;
            mins       <= '0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= load;
            if (load) begin
                mins     <= sec_tens;
                sec_tens <= sec_ones;
                sec_ones <= code;
            end
        end
    end

    assign entry_valid = (sec_ones != 4'd0) || (sec_tens != 4'd0) || (mins != 4'd0);

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset, with the ports named as follows.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable cycles required to accept a key.
REQ-003 Port clk, input, width 1: system clock; all state updates on the rising edge.
REQ-004 Port clear, input, width 1: asynchronous active-high reset.
REQ-005 Port keypad, input, width 10: one bit per key. bit0..bit8 are digits 1..9; bit9 is digit 0.
REQ-006 Port load_en, input, width 1: when high, the controller permits digit entry (not cooking).
REQ-007 Port sec_ones, output, width 4: BCD seconds-ones digit.
REQ-008 Port sec_tens, output, width 4: BCD seconds-tens digit.
REQ-009 Port mins, output, width 4: BCD minutes digit.
REQ-010 Port key_strobe, output, width 1: one-cycle pulse on each accepted digit.
REQ-011 Port entry_valid, output, width 1: high when any stored digit is nonzero.

Function
REQ-012 The sampled keypad SHALL be classified each cycle as one of three values:
- IDLE: all zero.
- ONEHOT: exactly one bit set.
- INVALID: two or more bits set.
REQ-013 The debouncer SHALL use the states WAIT_RELEASE, RELEASED, PRESSING and HELD.
REQ-014 Debounce state transitions SHALL be:
- WAIT_RELEASE to RELEASED after IDLE is stable for DEBOUNCE_CYCLES cycles.
- RELEASED to PRESSING when ONEHOT is seen; the cycle counter loads 1.
- PRESSING counts while the same ONEHOT code persists.
- PRESSING returns to RELEASED on any change of code, an IDLE, or an INVALID.
- PRESSING to HELD when the count reaches DEBOUNCE_CYCLES; this is the accept cycle.
- HELD to WAIT_RELEASE on the first non-matching sample.
REQ-015 A key held indefinitely SHALL produce exactly one accept.
REQ-016 INVALID in any state SHALL never produce an accept.
REQ-017 On an accept with load_en=1, the digits SHALL shift one place in the same edge:
- mins takes the old sec_tens.
- sec_tens takes the old sec_ones.
- sec_ones takes the encoded digit.
REQ-018 key_strobe SHALL be high for exactly the cycle after that edge.
REQ-019 On an accept with load_en=0, the digits SHALL be unchanged and key_strobe SHALL stay 0; the press is consumed and is not replayed later.
REQ-020 The old mins digit SHALL be discarded on a shift; entry wraps as a 3-digit shift window, with no saturation.
REQ-021 Digits SHALL be stored exactly as typed, with no validation of seconds-tens greater than 5; normalisation belongs to the downstream timer.
REQ-022 entry_valid SHALL be a combinational OR of nonzero tests on the three digit registers.
REQ-023 Latency SHALL be as follows:
- A clean press stable from cycle N is accepted at edge N+DEBOUNCE_CYCLES-1.
- The digits update at that same edge.
- key_strobe is visible the following cycle.

Reset
REQ-024 On clear=1, the module SHALL set sec_ones, sec_tens and mins to 0, key_strobe to 0, the debouncer state to WAIT_RELEASE and the counter to 0, all asynchronously.
REQ-025 A clear asserted mid-press SHALL abort that press; the key must be released, and IDLE stable for DEBOUNCE_CYCLES, before the next accept.

Structure
REQ-026 Package microwave_pkg SHALL hold the key-index constants, the BCD digit type, the debounce state encoding and the default DEBOUNCE_CYCLES.
REQ-027 The debouncer and classifier SHALL be one sub-module, key_debounce.
- It outputs a 1-cycle accept pulse and a 4-bit BCD code.
- keypad_entry holds only the shift register and its output logic.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Clean entry: after clear, press keys 1, 4, 5 (bit0, bit3, bit4), each held 6 cycles and released 6 cycles, with load_en=1. Required: mins=1, sec_tens=4, sec_ones=5, three key_strobe pulses, entry_valid=1.
- Bounce: keypad toggles between bit2 and 0 every cycle for 10 cycles, then holds bit2 for 4 cycles. Required: exactly one accept, sec_ones=3.
- Multi-key: bit0 and bit1 set together for 20 cycles. Required: no strobe, digits unchanged.
- Wrap: enter 1, 2, 3, 4. Required: mins=2, sec_tens=3, sec_ones=4.
- load_en gating: with load_en=0, press key 7 and release; then set load_en=1 without re-pressing. Required: digits unchanged, no strobe.
- Clear mid-press: assert clear 2 cycles into a press of bit9, deassert it, and keep the key held. Required: all outputs 0, no accept until release and re-press.
